// File: rtl/capture_pkg.sv
// capture_pkg: shared types and helpers for the event capture block.
// Rev 1.0
`default_nettype none

package capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POST    = 2'd1,
    ST_READOUT = 2'd2
  } state_e;

  typedef logic [15:0] cnt16_t;

  function automatic cnt16_t sat_inc(input cnt16_t v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/event_capture_if.sv
// event_capture_if: valid/ready readout stream carrying one sample per beat plus a last flag.
// Rev 1.0
`default_nettype none

interface event_capture_if #(
  parameter int SAMPLE_W = 12
);
  logic [SAMPLE_W-1:0] data;
  logic                valid;
  logic                ready;
  logic                last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

`default_nettype wire

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample ring storage with a registered read port; contents are never reset.
// Rev 1.0
`default_nettype none

module capture_ram #(
  parameter int SAMPLE_W = 12,
  parameter int DEPTH    = 64,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  wire logic                clk,
  input  wire logic                we,
  input  wire logic [ADDR_W-1:0]   waddr,
  input  wire logic [SAMPLE_W-1:0] wdata,
  input  wire logic                re,
  input  wire logic [ADDR_W-1:0]   raddr,
  output logic      [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/event_capture.sv
// event_capture: freezes a pre/post-trigger window of ADC samples in a ring and streams it out.
// Rev 1.0
`default_nettype none

module event_capture
  import capture_pkg::*;
#(
  parameter int SAMPLE_W     = 12,
  parameter int DEPTH        = 64,
  parameter int PRE_SAMPLES  = 16,
  parameter int POST_SAMPLES = 48
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic [SAMPLE_W-1:0] adc_data,
  input  wire logic                adc_valid,
  input  wire logic                trigger_in,
  input  wire logic                enable,
  event_capture_if.master          evt,
  output logic                     busy,
  output cnt16_t                   event_count,
  output cnt16_t                   dropped_count
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int WIN_LEN = PRE_SAMPLES + POST_SAMPLES;
  localparam int PF_W    = $clog2(PRE_SAMPLES + 1);
  localparam int PC_W    = $clog2(POST_SAMPLES + 1);
  localparam int RC_W    = $clog2(WIN_LEN + 1);

  localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE_SAMPLES);
  localparam logic [PF_W-1:0]   PRE_N     = PF_W'(PRE_SAMPLES);
  localparam logic [PC_W-1:0]   POST_LAST = PC_W'(POST_SAMPLES - 1);
  localparam logic [RC_W-1:0]   WIN_N     = RC_W'(WIN_LEN);
  localparam logic [RC_W-1:0]   WIN_LAST  = RC_W'(WIN_LEN - 1);

  state_e              state_q, state_d;
  logic                trig_q;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PF_W-1:0]     prefill_q, prefill_d;
  logic [PC_W-1:0]     post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [RC_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic                ram_vld_q, ram_vld_d;
  logic                ram_last_q, ram_last_d;
  logic [SAMPLE_W-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [SAMPLE_W-1:0] skid_data_q, skid_data_d;
  logic                skid_valid_q, skid_valid_d;
  logic                skid_last_q, skid_last_d;
  cnt16_t              event_cnt_q, event_cnt_d;
  cnt16_t              dropped_cnt_q, dropped_cnt_d;

  logic                trig_en;
  logic                fire;
  logic                ram_we;
  logic                rd_issue;
  logic [SAMPLE_W-1:0] ram_rdata;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    prefill_d     = prefill_q;
    post_cnt_d    = post_cnt_q;
    rd_addr_d     = rd_addr_q;
    rd_cnt_d      = rd_cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    skid_data_d   = skid_data_q;
    skid_valid_d  = skid_valid_q;
    skid_last_d   = skid_last_q;
    event_cnt_d   = event_cnt_q;
    dropped_cnt_d = dropped_cnt_q;

    trig_en = trigger_in & ~trig_q & enable;
    fire    = out_valid_q & evt.ready;
    ram_we  = adc_valid & (state_q != ST_READOUT);

    if (ram_we) wr_ptr_d = wr_ptr_q + ADDR_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (ram_we && prefill_q != PRE_N) prefill_d = prefill_q + PF_W'(1);
        if (trig_en) begin
          if (prefill_q == PRE_N) begin
            state_d    = ST_POST;
            rd_addr_d  = wr_ptr_q - PRE_A;
            rd_cnt_d   = '0;
            // A sample arriving with the accepting edge is post sample 0.
            post_cnt_d = adc_valid ? PC_W'(1) : '0;
            if (adc_valid && POST_SAMPLES == 1) state_d = ST_READOUT;
          end else begin
            dropped_cnt_d = sat_inc(dropped_cnt_q);
          end
        end
      end
      ST_POST: begin
        if (trig_en) dropped_cnt_d = sat_inc(dropped_cnt_q);
        if (adc_valid) begin
          post_cnt_d = post_cnt_q + PC_W'(1);
          if (post_cnt_q == POST_LAST) state_d = ST_READOUT;
        end
      end
      ST_READOUT: begin
        if (trig_en) dropped_cnt_d = sat_inc(dropped_cnt_q);
        if (fire && out_last_q) begin
          state_d     = ST_IDLE;
          prefill_d   = '0;
          event_cnt_d = sat_inc(event_cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output register refills from the skid first, then from the RAM port.
    if (!out_valid_q || fire) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_valid_d  = 1'b1;
        skid_valid_d = ram_vld_q;
        skid_data_d  = ram_rdata;
        skid_last_d  = ram_last_q;
      end else if (ram_vld_q) begin
        out_data_d  = ram_rdata;
        out_last_d  = ram_last_q;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (ram_vld_q) begin
      skid_data_d  = ram_rdata;
      skid_last_d  = ram_last_q;
      skid_valid_d = 1'b1;
    end

    // Only issue a read when the skid is guaranteed free to absorb it.
    rd_issue   = (state_q == ST_READOUT) && (rd_cnt_q != WIN_N) && !skid_valid_d;
    ram_vld_d  = rd_issue;
    ram_last_d = rd_issue && (rd_cnt_q == WIN_LAST);
    if (rd_issue) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
      rd_cnt_d  = rd_cnt_q + RC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      trig_q        <= 1'b0;
      wr_ptr_q      <= '0;
      prefill_q     <= '0;
      post_cnt_q    <= '0;
      rd_addr_q     <= '0;
      rd_cnt_q      <= '0;
      ram_vld_q     <= 1'b0;
      ram_last_q    <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      skid_data_q   <= '0;
      skid_valid_q  <= 1'b0;
      skid_last_q   <= 1'b0;
      event_cnt_q   <= '0;
      dropped_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      trig_q        <= trigger_in;
      wr_ptr_q      <= wr_ptr_d;
      prefill_q     <= prefill_d;
      post_cnt_q    <= post_cnt_d;
      rd_addr_q     <= rd_addr_d;
      rd_cnt_q      <= rd_cnt_d;
      ram_vld_q     <= ram_vld_d;
      ram_last_q    <= ram_last_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      skid_data_q   <= skid_data_d;
      skid_valid_q  <= skid_valid_d;
      skid_last_q   <= skid_last_d;
      event_cnt_q   <= event_cnt_d;
      dropped_cnt_q <= dropped_cnt_d;
    end
  end

  capture_ram #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (adc_data),
    .re    (rd_issue),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  assign evt.data      = out_data_q;
  assign evt.valid     = out_valid_q;
  assign evt.last      = out_last_q;
  assign busy          = (state_q != ST_IDLE);
  assign event_count   = event_cnt_q;
  assign dropped_count = dropped_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_event_capture.sv
// tb_event_capture: directed self-checking bench for event_capture.
// Rev 1.0
`default_nettype none

module tb_event_capture;
  import capture_pkg::*;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic [11:0] adc_data   = '0;
  logic        adc_valid  = 1'b0;
  logic        trigger_in = 1'b0;
  logic        enable     = 1'b1;
  logic        busy;
  cnt16_t      event_count;
  cnt16_t      dropped_count;

  bit adc_on   = 1'b0;
  bit adc_rand = 1'b0;
  int n_valid  = 0;
  int checks   = 0;
  int passed   = 0;
  int d;

  event_capture_if #(.SAMPLE_W(12)) evt_if();

  event_capture #(
    .SAMPLE_W     (12),
    .DEPTH        (64),
    .PRE_SAMPLES  (16),
    .POST_SAMPLES (48)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .trigger_in    (trigger_in),
    .enable        (enable),
    .evt           (evt_if),
    .busy          (busy),
    .event_count   (event_count),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_valid();
    adc_valid = adc_on && (adc_rand ? ($urandom_range(0, 9) < 3) : 1'b1);
  endtask

  // Stream source: the sample value steps only when the previous one was taken.
  task automatic tick();
    @(posedge clk);
    #1;
    if (adc_valid) begin
      adc_data = adc_data + 12'd1;
      n_valid++;
    end
    set_valid();
  endtask

  task automatic do_reset();
    adc_on = 1'b0; adc_valid = 1'b0; trigger_in = 1'b0; evt_if.ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1; adc_data = '0; n_valid = 0; adc_on = 1'b1;
    set_valid();
  endtask

  task automatic trig(output int dval);
    dval = int'(adc_data);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
  endtask

  task automatic collect(input int first, input int stop_at, input int trig_word, input bit rnd);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    bit pulsed = 0;
    logic [11:0] sd = '0;
    logic sl = 1'b0;
    while (got < stop_at && cyc < 3000) begin
      evt_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      trigger_in = 1'b0;
      if (trig_word >= 0 && got == trig_word && !pulsed) begin
        trigger_in = 1'b1;
        pulsed = 1;
      end
      if (stalled) begin
        check("hold_valid", 32'(evt_if.valid), 32'd1);
        check("hold_data", 32'(evt_if.data), 32'(sd));
        check("hold_last", 32'(evt_if.last), 32'(sl));
      end
      if (evt_if.valid && evt_if.ready) begin
        check("data", 32'(evt_if.data), 32'((first + got) & 'hFFF));
        check("last", 32'(evt_if.last), 32'(got == 63));
        got++;
      end
      stalled = evt_if.valid && !evt_if.ready;
      sd = evt_if.data;
      sl = evt_if.last;
      tick();
      cyc++;
    end
    trigger_in = 1'b0;
    check("words", 32'(got), 32'(stop_at));
    if (stop_at == 64) begin
      check("valid_after", 32'(evt_if.valid), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    evt_if.ready = 1'b0;
    do_reset();
    check("rst_valid", 32'(evt_if.valid), 32'd0);
    check("rst_last", 32'(evt_if.last), 32'd0);
    check("rst_data", 32'(evt_if.data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_events", 32'(event_count), 32'd0);
    check("rst_dropped", 32'(dropped_count), 32'd0);

    // 1: trigger at wr_ptr=20 -> words 0x004..0x043
    repeat (20) tick();
    trig(d);
    check("t1_busy", 32'(busy), 32'd1);
    collect(4, 64, -1, 0);
    check("t1_events", 32'(event_count), 32'd1);
    check("t1_dropped", 32'(dropped_count), 32'd0);

    // 2: trigger at wr_ptr=8 after a full lap -> read starts at addr 56, data 56..119
    do_reset();
    repeat (72) tick();
    trig(d);
    collect(56, 64, -1, 0);
    check("t2_events", 32'(event_count), 32'd1);

    // 3: unprimed trigger is dropped, later one accepted (wr_ptr=21 -> first word 5)
    do_reset();
    repeat (10) tick();
    trig(d);
    repeat (5) tick();
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_dropped", 32'(dropped_count), 32'd1);
    repeat (5) tick();
    trig(d);
    check("t3_busy2", 32'(busy), 32'd1);
    collect(5, 64, -1, 0);
    check("t3_events", 32'(event_count), 32'd1);
    check("t3_dropped2", 32'(dropped_count), 32'd1);

    // 4: edges during POST and READOUT are dropped; a held level triggers once
    do_reset();
    repeat (20) tick();
    trig(d);
    repeat (10) tick();
    trig(d);
    collect(4, 64, 10, 0);
    check("t4_dropped", 32'(dropped_count), 32'd2);
    repeat (20) tick();
    d = int'(adc_data);
    trigger_in = 1'b1;
    evt_if.ready = 1'b0;
    repeat (100) tick();
    trigger_in = 1'b0;
    check("t4_hold_busy", 32'(busy), 32'd1);
    collect(d - 16, 64, -1, 0);
    check("t4_events", 32'(event_count), 32'd2);
    check("t4_dropped2", 32'(dropped_count), 32'd2);

    // 5: sparse ADC and random READY
    adc_rand = 1'b1;
    do_reset();
    while (n_valid < 20) tick();
    trig(d);
    collect(d - 16, 64, -1, 1);
    check("t5_events", 32'(event_count), 32'd1);
    adc_rand = 1'b0;
    set_valid();

    // 6: reset mid-readout, disabled trigger ignored, capture resumes
    repeat (20) tick();
    trig(d);
    collect(d - 16, 20, -1, 0);
    check("t6_pre_events", 32'(event_count), 32'd1);
    rst_n = 1'b0; adc_on = 1'b0; adc_valid = 1'b0;
    #1;
    check("t6_rst_valid", 32'(evt_if.valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_events", 32'(event_count), 32'd0);
    check("t6_rst_data", 32'(evt_if.data), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1; adc_on = 1'b1;
    set_valid();
    enable = 1'b0;
    repeat (20) tick();
    trig(d);
    repeat (5) tick();
    check("t6_dis_busy", 32'(busy), 32'd0);
    check("t6_dis_dropped", 32'(dropped_count), 32'd0);
    check("t6_dis_events", 32'(event_count), 32'd0);
    enable = 1'b1;
    trig(d);
    collect(d - 16, 64, -1, 0);
    check("t6_events", 32'(event_count), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
